// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, issues single-outstanding word reads to
// instruction memory and buffers returned words with their PC for the decoder.
module instr_fetch #(
  parameter int              ARCH       = 32,
  parameter logic [ARCH-1:0] RESET_ADDR = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_out,
  output logic [ARCH-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [ARCH-1:0] imem_rdata_in,
  input  logic            redirect_in,
  input  logic [ARCH-1:0] redirect_addr_in,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [ARCH-1:0] instr_out,
  output logic [ARCH-1:0] pc_out,
  output logic [1:0]      fsm_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ARCH-1:0]   pc, pc_nxt, req_pc;
  logic [ARCH-1:0]   buf_pc    [FIFO_DEPTH];
  logic [ARCH-1:0]   buf_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              outstanding, gated, grant, push, pop;

  // Buffer space is reserved for the in-flight fetch, so overflow cannot happen.
  assign outstanding = (state == WAIT) || (state == DISCARD);
  assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
  assign gated       = occupancy >= {1'b0, DEPTH_C};

  assign imem_req_out  = (state == REQ) && !gated;
  assign imem_addr_out = pc;
  assign grant         = imem_req_out && imem_gnt_in;
  assign push          = (state == WAIT) && imem_rvalid_in && !redirect_in;
  assign pop           = instr_valid_out && instr_ready_in;
  assign fsm_state     = state;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ: begin
        if (grant) begin
          state_nxt = WAIT;
          pc_nxt    = pc + ARCH'(4);
        end
      end
      WAIT:    if (imem_rvalid_in) state_nxt = REQ;
      DISCARD: if (imem_rvalid_in) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    // Redirect wins: a fetch granted or still in flight now belongs to the old stream.
    if (redirect_in) begin
      pc_nxt = redirect_addr_in & ~ARCH'(3);
      case (state)
        REQ:     if (grant) state_nxt = DISCARD;
        WAIT:    state_nxt = imem_rvalid_in ? REQ : DISCARD;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_ADDR;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (grant) req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= req_pc;
      buf_instr[wr_ptr] <= imem_rdata_in;
    end
  end

  assign instr_valid_out = (count != '0);
  assign instr_out       = instr_valid_out ? buf_instr[rd_ptr] : '0;
  assign pc_out          = instr_valid_out ? buf_pc[rd_ptr]    : '0;

  rvalid_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid_in |-> outstanding);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory responder with configurable gnt/rvalid delays
// feeds a scoreboard that checks every delivered {pc, instr} in program order.
module tb_instr_fetch;

  localparam int          ARCH       = 32;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_REQ      = 2'd1;
  localparam logic [1:0]  S_WAIT     = 2'd2;
  localparam logic [1:0]  S_DISCARD  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_addr_in = '0;
  logic        instr_valid_out;
  logic        instr_ready_in = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  instr_fetch #(.ARCH(ARCH), .RESET_ADDR(RESET_ADDR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .redirect_in(redirect_in), .redirect_addr_in(redirect_addr_in),
    .instr_valid_out(instr_valid_out), .instr_ready_in(instr_ready_in),
    .instr_out(instr_out), .pc_out(pc_out), .fsm_state(fsm_state)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_next_pc = RESET_ADDR;
  int          pops = 0;
  int          grants = 0;
  int          addr_changes = 0;
  int          gnt_delay = 0;
  int          rvalid_delay = 1;
  int          gnt_wait = 0;
  int          rsp_cnt = 0;
  logic        rsp_pending = 1'b0;
  logic        rsp_stale = 1'b0;
  logic [31:0] rsp_addr = '0;
  logic [31:0] held_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  // One clock cycle: inputs for this cycle are already set by the caller.
  task automatic tick();
    logic [63:0] e;
    imem_gnt_in    = 1'b0;
    imem_rvalid_in = 1'b0;
    if (!rst_n) begin
      rsp_pending = 1'b0;
      rsp_stale   = 1'b0;
      gnt_wait    = 0;
      exp_q.delete();
      exp_next_pc = RESET_ADDR;
    end else begin
      if (instr_valid_out && instr_ready_in) begin
        pops++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h, expected nothing", pc_out, instr_out);
        end else begin
          e = exp_q.pop_front();
          if ({pc_out, instr_out} !== e) begin
            n_errors++;
            $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                     pc_out, instr_out, e[63:32], e[31:0]);
          end
        end
        n_checks++;
        if (pc_out !== exp_next_pc) begin
          n_errors++;
          $display("FAIL sb_order: got pc=%h, expected pc=%h", pc_out, exp_next_pc);
        end
        exp_next_pc = exp_next_pc + 32'd4;
      end
      if (redirect_in) begin
        exp_q.delete();
        exp_next_pc = redirect_addr_in & ~32'd3;
      end
      if (rsp_pending) begin
        if (rsp_cnt == 0) begin
          imem_rvalid_in = 1'b1;
          imem_rdata_in  = mem_word(rsp_addr);
          rsp_pending    = 1'b0;
          if (!rsp_stale && !redirect_in) exp_q.push_back({rsp_addr, mem_word(rsp_addr)});
        end else begin
          rsp_cnt--;
        end
        if (redirect_in) rsp_stale = 1'b1;
      end
      if (imem_req_out) begin
        if (gnt_wait == 0) held_addr = imem_addr_out;
        else if (imem_addr_out !== held_addr) addr_changes++;
        if (gnt_wait >= gnt_delay) begin
          imem_gnt_in = 1'b1;
          grants++;
          gnt_wait    = 0;
          rsp_pending = 1'b1;
          rsp_stale   = redirect_in;
          rsp_cnt     = rvalid_delay - 1;
          rsp_addr    = imem_addr_out;
        end else begin
          gnt_wait++;
        end
      end else begin
        gnt_wait = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    instr_ready_in = 1'b1;
    gnt_delay      = 0;
    rvalid_delay   = 1;
    rst_n          = 1'b0;
    tick();
    n_checks += 6;
    if (imem_req_out !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b, expected 0", imem_req_out); end
    if (imem_addr_out !== RESET_ADDR) begin n_errors++; $display("FAIL reset_addr: got %h, expected %h", imem_addr_out, RESET_ADDR); end
    if (instr_valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, expected 0", instr_valid_out); end
    if (instr_out !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h, expected 0", instr_out); end
    if (pc_out !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h, expected 0", pc_out); end
    if (fsm_state !== S_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d, expected %0d", fsm_state, S_IDLE); end
    rst_n = 1'b1;
    pops  = 0;
    tick();
    tick();
    n_checks++;
    if (instr_valid_out !== 1'b0) begin n_errors++; $display("FAIL first_latency_early: valid=%b, expected 0", instr_valid_out); end
    tick();
    n_checks += 3;
    if (instr_valid_out !== 1'b1) begin n_errors++; $display("FAIL first_latency: valid=%b, expected 1", instr_valid_out); end
    if (pc_out !== 32'h0) begin n_errors++; $display("FAIL first_pc: got %h, expected 0", pc_out); end
    if (instr_out !== 32'h0) begin n_errors++; $display("FAIL first_instr: got %h, expected 0", instr_out); end
    for (int i = 0; i < 40 && pops < 3; i++) tick();
    n_checks++;
    if (pops < 3) begin n_errors++; $display("FAIL stream_timeout: got %0d pops, expected >= 3", pops); end
  endtask

  task automatic test_backpressure();
    instr_ready_in = 1'b0;
    do_reset();
    grants = 0;
    for (int i = 0; i < 12; i++) tick();
    n_checks += 6;
    if (grants !== 2) begin n_errors++; $display("FAIL bp_grants: got %0d, expected 2", grants); end
    if (imem_req_out !== 1'b0) begin n_errors++; $display("FAIL bp_req_gated: got %b, expected 0", imem_req_out); end
    if (instr_valid_out !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %b, expected 1", instr_valid_out); end
    if (instr_out !== 32'h0) begin n_errors++; $display("FAIL bp_instr: got %h, expected 0", instr_out); end
    if (pc_out !== 32'h0) begin n_errors++; $display("FAIL bp_pc: got %h, expected 0", pc_out); end
    if (fsm_state !== S_REQ) begin n_errors++; $display("FAIL bp_state: got %0d, expected %0d", fsm_state, S_REQ); end
    instr_ready_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req_out) break;
    end
    n_checks++;
    if (!imem_req_out || imem_addr_out !== 32'h8) begin
      n_errors++;
      $display("FAIL bp_resume: req=%b addr=%h, expected req=1 addr=00000008", imem_req_out, imem_addr_out);
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_redirect_wait();
    instr_ready_in = 1'b1;
    gnt_delay      = 0;
    rvalid_delay   = 3;
    do_reset();
    for (int i = 0; i < 60 && !(imem_req_out && imem_addr_out == 32'h10); i++) tick();
    n_checks++;
    if (!(imem_req_out && imem_addr_out == 32'h10)) begin
      n_errors++; $display("FAIL rw_find_0x10: req=%b addr=%h, expected req=1 addr=00000010", imem_req_out, imem_addr_out);
    end
    tick();
    n_checks++;
    if (fsm_state !== S_WAIT) begin n_errors++; $display("FAIL rw_in_wait: got %0d, expected %0d", fsm_state, S_WAIT); end
    redirect_in      = 1'b1;
    redirect_addr_in = 32'h103;
    tick();
    redirect_in = 1'b0;
    n_checks++;
    if (fsm_state !== S_DISCARD) begin n_errors++; $display("FAIL rw_discard: got %0d, expected %0d", fsm_state, S_DISCARD); end
    for (int i = 0; i < 20 && !imem_req_out; i++) tick();
    n_checks++;
    if (!imem_req_out || imem_addr_out !== 32'h100) begin
      n_errors++; $display("FAIL rw_new_addr: req=%b addr=%h, expected req=1 addr=00000100", imem_req_out, imem_addr_out);
    end
    for (int i = 0; i < 20 && !instr_valid_out; i++) tick();
    n_checks += 2;
    if (pc_out !== 32'h100) begin n_errors++; $display("FAIL rw_first_pc: got %h, expected 00000100", pc_out); end
    if (instr_out !== 32'h40) begin n_errors++; $display("FAIL rw_first_instr: got %h, expected 00000040", instr_out); end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_redirect_gnt();
    instr_ready_in = 1'b1;
    gnt_delay      = 0;
    rvalid_delay   = 1;
    do_reset();
    for (int i = 0; i < 60 && !(imem_req_out && imem_addr_out == 32'h20); i++) tick();
    n_checks++;
    if (!(imem_req_out && imem_addr_out == 32'h20)) begin
      n_errors++; $display("FAIL rg_find_0x20: req=%b addr=%h, expected req=1 addr=00000020", imem_req_out, imem_addr_out);
    end
    redirect_in      = 1'b1;
    redirect_addr_in = 32'h200;
    tick();
    redirect_in = 1'b0;
    n_checks++;
    if (fsm_state !== S_DISCARD) begin n_errors++; $display("FAIL rg_discard: got %0d, expected %0d", fsm_state, S_DISCARD); end
    for (int i = 0; i < 20 && !imem_req_out; i++) tick();
    n_checks++;
    if (!imem_req_out || imem_addr_out !== 32'h200) begin
      n_errors++; $display("FAIL rg_new_addr: req=%b addr=%h, expected req=1 addr=00000200", imem_req_out, imem_addr_out);
    end
    for (int i = 0; i < 20 && !instr_valid_out; i++) tick();
    n_checks++;
    if (pc_out !== 32'h200) begin n_errors++; $display("FAIL rg_first_pc: got %h, expected 00000200", pc_out); end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_stall();
    instr_ready_in = 1'b1;
    gnt_delay      = 3;
    rvalid_delay   = 4;
    do_reset();
    addr_changes = 0;
    pops         = 0;
    for (int i = 0; i < 200 && pops < 6; i++) begin
      instr_ready_in = ($urandom_range(0, 3) != 0);
      tick();
    end
    instr_ready_in = 1'b1;
    n_checks += 2;
    if (pops < 6) begin n_errors++; $display("FAIL stall_timeout: got %0d pops, expected >= 6", pops); end
    if (addr_changes !== 0) begin n_errors++; $display("FAIL stall_addr_stable: got %0d changes, expected 0", addr_changes); end
    gnt_delay    = 0;
    rvalid_delay = 1;
  endtask

  task automatic test_wrap_and_reset();
    instr_ready_in = 1'b1;
    gnt_delay      = 0;
    rvalid_delay   = 1;
    do_reset();
    redirect_in      = 1'b1;
    redirect_addr_in = 32'hFFFF_FFFF;
    tick();
    redirect_in = 1'b0;
    n_checks++;
    if (!imem_req_out || imem_addr_out !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_idle_redirect: req=%b addr=%h, expected req=1 addr=fffffffc", imem_req_out, imem_addr_out);
    end
    tick();
    for (int i = 0; i < 20 && !imem_req_out; i++) tick();
    n_checks++;
    if (!imem_req_out || imem_addr_out !== 32'h0) begin
      n_errors++; $display("FAIL wrap_addr: req=%b addr=%h, expected req=1 addr=00000000", imem_req_out, imem_addr_out);
    end
    n_checks += 2;
    if (pc_out !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_pc: got %h, expected fffffffc", pc_out); end
    if (instr_out !== 32'h3FFF_FFFF) begin n_errors++; $display("FAIL wrap_instr: got %h, expected 3fffffff", instr_out); end
    instr_ready_in = 1'b0;
    for (int i = 0; i < 20 && !(fsm_state == S_WAIT && instr_valid_out); i++) tick();
    n_checks++;
    if (!(fsm_state == S_WAIT && instr_valid_out)) begin
      n_errors++; $display("FAIL arst_setup: state=%0d valid=%b, expected state=%0d valid=1", fsm_state, instr_valid_out, S_WAIT);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (imem_req_out !== 1'b0) begin n_errors++; $display("FAIL arst_req: got %b, expected 0", imem_req_out); end
    if (imem_addr_out !== RESET_ADDR) begin n_errors++; $display("FAIL arst_addr: got %h, expected %h", imem_addr_out, RESET_ADDR); end
    if (instr_valid_out !== 1'b0) begin n_errors++; $display("FAIL arst_valid: got %b, expected 0", instr_valid_out); end
    if (instr_out !== 32'h0) begin n_errors++; $display("FAIL arst_instr: got %h, expected 0", instr_out); end
    if (pc_out !== 32'h0) begin n_errors++; $display("FAIL arst_pc: got %h, expected 0", pc_out); end
    if (fsm_state !== S_IDLE) begin n_errors++; $display("FAIL arst_state: got %0d, expected %0d", fsm_state, S_IDLE); end
    tick();
    rst_n          = 1'b1;
    instr_ready_in = 1'b1;
    for (int i = 0; i < 10 && !imem_req_out; i++) tick();
    n_checks++;
    if (!imem_req_out || imem_addr_out !== RESET_ADDR) begin
      n_errors++; $display("FAIL arst_restart: req=%b addr=%h, expected req=1 addr=%h", imem_req_out, imem_addr_out, RESET_ADDR);
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_stall();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
